// File: rtl/instruction_fetch_stage_if.sv
// Bus bundle between the fetch stage, the instruction memory and the decode stage.
// The fetch stage uses the master modport. Its environment (memory plus decode) uses the slave modport.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W = 8
);
  // Instruction memory read port
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  // Pipeline control from downstream stages
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  // Issued instruction towards decode/execute
  logic [31:0]       instr_out;
  logic [31:0]       pc_out;
  logic [31:0]       pc_plus4_out;
  logic              instr_valid;

  // Error reporting and statistics
  logic              fault;
  logic [31:0]       fault_pc;
  logic [31:0]       fetch_count;

  // Debug view of the fetch FSM state
  logic [1:0]        fsm_state;

  modport master (
    input  imem_rdata, stall, redirect_valid, redirect_pc,
    output imem_addr, instr_out, pc_out, pc_plus4_out, instr_valid,
    output fault, fault_pc, fetch_count, fsm_state
  );

  modport slave (
    output imem_rdata, stall, redirect_valid, redirect_pc,
    input  imem_addr, instr_out, pc_out, pc_plus4_out, instr_valid,
    input  fault, fault_pc, fetch_count, fsm_state
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC and reads big-endian words from byte-addressed imem.
// Issues {pc, instr} with a valid flag. Supports stall, redirect with a bubble, and a sticky illegal-target fault.
module instruction_fetch_stage #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_fetch_stage_if.master   bus
);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam int PAD_W = 32 - ADDR_W;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [31:0]       instr_q;
  logic [31:0]       pc_out_q;
  logic [31:0]       pc_plus4_q;
  logic              valid_q;
  logic              fault_q;
  logic [31:0]       fault_pc_q;
  logic [31:0]       count_q;
  logic              target_misaligned;
  logic              target_out_of_range;
  logic              target_illegal;

  // The sequential PC wraps modulo the memory size, so the upper PC bits stay zero.
  assign pc_next_seq = pc + ADDR_W'(4);

  assign target_misaligned   = (bus.redirect_pc[1:0] != 2'b00);
  assign target_out_of_range = (bus.redirect_pc[31:ADDR_W] != '0);
  assign target_illegal      = target_misaligned | target_out_of_range;

  // Handshake: instr_valid=1 marks {instr_out, pc_out, pc_plus4_out} as a real instruction.
  // stall=1 means downstream is not ready, so every register holds. A redirect always wins over a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_START;
      pc         <= RESET_PC[ADDR_W-1:0];
      instr_q    <= 32'h0;
      pc_out_q   <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
      count_q    <= 32'h0;
    end else begin
      case (state)
        ST_START: begin
          valid_q <= 1'b0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.redirect_valid && target_illegal) begin
            state      <= ST_FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= bus.redirect_pc;
            valid_q    <= 1'b0;
          end else if (bus.redirect_valid) begin
            // Bubble: the old instruction/pc stay visible but are marked invalid.
            pc      <= bus.redirect_pc[ADDR_W-1:0];
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            instr_q    <= bus.imem_rdata;
            pc_out_q   <= {{PAD_W{1'b0}}, pc};
            pc_plus4_q <= {{PAD_W{1'b0}}, pc_next_seq};
            valid_q    <= 1'b1;
            pc         <= pc_next_seq;
            count_q    <= count_q + 32'd1;
          end
        end
        ST_FAULT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state   <= ST_FAULT;
          fault_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.pc_plus4_out = pc_plus4_q;
  assign bus.instr_valid  = valid_q;
  assign bus.fault        = fault_q;
  assign bus.fault_pc     = fault_pc_q;
  assign bus.fetch_count  = count_q;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed and random bench for instruction_fetch_stage against a spec-level reference model.
module tb_instruction_fetch_stage;
  localparam int ADDR_W    = 8;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic clk;
  logic reset;

  instruction_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory ----------------
  logic [7:0] mem [MEM_BYTES];
  assign bus.imem_rdata = {mem[bus.imem_addr], mem[bus.imem_addr + 8'd1],
                           mem[bus.imem_addr + 8'd2], mem[bus.imem_addr + 8'd3]};

  // ---------------- reference model ----------------
  int          m_pc;
  bit          m_started;
  bit          m_faulted;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_pc_out;
  int          m_pc4;
  logic [31:0] m_fault_pc;
  logic [31:0] m_count;

  int checks;
  int failures;

  function automatic logic [31:0] word_at(input int a);
    return {mem[a % MEM_BYTES], mem[(a + 1) % MEM_BYTES],
            mem[(a + 2) % MEM_BYTES], mem[(a + 3) % MEM_BYTES]};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_started = 0; m_faulted = 0; m_valid = 0;
    m_instr = 0; m_pc_out = 0; m_pc4 = 0; m_fault_pc = 0; m_count = 0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rpc);
    if (m_faulted) begin
      m_valid = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (rv && (rpc % 4 != 0 || rpc >= 32'(MEM_BYTES))) begin
      m_faulted = 1; m_fault_pc = rpc; m_valid = 0;
    end else if (rv) begin
      m_pc = int'(rpc); m_valid = 0;
    end else if (!s) begin
      m_instr  = word_at(m_pc);
      m_pc_out = m_pc;
      m_pc4    = (m_pc + 4) % MEM_BYTES;
      m_valid  = 1;
      m_pc     = (m_pc + 4) % MEM_BYTES;
      m_count  = m_count + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".valid"},    {31'b0, bus.instr_valid}, {31'b0, m_valid});
    check({ctx, ".instr"},    bus.instr_out,            m_instr);
    check({ctx, ".pc_out"},   bus.pc_out,               32'(m_pc_out));
    check({ctx, ".pc4"},      bus.pc_plus4_out,         32'(m_pc4));
    check({ctx, ".count"},    bus.fetch_count,          m_count);
    check({ctx, ".fault"},    {31'b0, bus.fault},       {31'b0, m_faulted});
    check({ctx, ".fault_pc"}, bus.fault_pc,             m_fault_pc);
    check({ctx, ".imem_addr"}, {24'b0, bus.imem_addr},  32'(m_pc));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string ctx, input logic s, input logic rv, input logic [31:0] rpc);
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    @(posedge clk);
    model_edge(s, rv, rpc);
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h20; mem[1] = 8'h0a; mem[2] = 8'h00; mem[3] = 8'h0a;

    // T1: reset state, START bubble, first fetch
    do_reset();
    step("t1_start", 0, 0, 0);
    step("t1_first", 0, 0, 0);
    check("t1_word", bus.instr_out, 32'h200a000a);
    check("t1_pc4", bus.pc_plus4_out, 32'h4);

    // Random mix of fetch, stall and legal redirects
    for (int i = 0; i < 60; i++) begin
      logic s, rv;
      logic [31:0] t;
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      t  = 32'($urandom_range(0, MEM_BYTES / 4 - 1)) * 32'd4;
      step("rand", s, rv, t);
    end

    // T2: three-cycle stall mid-stream
    step("t2_pre", 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2_stall", 1, 0, 0);
    step("t2_resume", 0, 0, 0);
    step("t2_next", 0, 0, 0);

    // T3: redirect overrides a simultaneous stall
    step("t3_redir", 1, 1, 32'h10);
    step("t3_fetch", 0, 0, 0);
    check("t3_pc_out", bus.pc_out, 32'h10);

    // T4: PC wrap at top of memory
    step("t4_redir", 0, 1, 32'hFC);
    step("t4_fc", 0, 0, 0);
    check("t4_pc4_wrap", bus.pc_plus4_out, 32'h0);
    step("t4_00", 0, 0, 0);
    check("t4_pc_wrap", bus.pc_out, 32'h0);

    // T5a: misaligned target faults and stays faulted
    step("t5_mis", 0, 1, 32'h102);
    check("t5_fault_pc", bus.fault_pc, 32'h102);
    for (int i = 0; i < 6; i++)
      step("t5_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 63)) * 32'd4);

    // T5b: out-of-range target after reset
    do_reset();
    step("t5b_start", 0, 0, 0);
    step("t5b_f0", 0, 0, 0);
    step("t5b_oor", 0, 1, 32'h100);
    step("t5b_hold", 0, 1, 32'h8);
    step("t5b_hold2", 1, 0, 0);

    // T6: asynchronous reset between edges while valid
    do_reset();
    step("t6_start", 0, 0, 0);
    step("t6_f0", 0, 0, 0);
    step("t6_f1", 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    reset = 1'b0;
    step("t6_start2", 0, 0, 0);
    step("t6_first", 0, 0, 0);
    check("t6_from_reset_pc", bus.pc_out, 32'h0);
    for (int i = 0; i < 10; i++) step("t6_run", 1'($urandom_range(0, 1)), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
